serial_adder_ctrl: RTL and testbench

- Bit-serial add controller built around one shared `full_adder` cell.
- Adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, feeding one bit pair per cycle through the cell.
- Holds the running carry in a flop and assembles the sum in a shift register.
- Trades area for latency; sits between an operand source and a result consumer using a start/done handshake.

---
 rtl/serial_adder_ctrl_pkg.sv | 18 +
 rtl/serial_adder_ctrl_if.sv | 17 +
 rtl/serial_adder_ctrl_full_adder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and a constant-time ceil(log2) helper for sizing the bit counter.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bus between an operand source
// (master) and the serial adder controller (slave).
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (output start, a, b, ci, input busy, done, sum, co);
  modport slave  (input start, a, b, ci, output busy, done, sum, co);
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell processes one bit pair per cycle,
// LSB first, with the sum assembled in a right-shifting register.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path through the case can infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.ci;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        carry_d = fa_co;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // Result registers update only here, so sum/co never expose partial bits.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          co_d    = fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: expected {co,sum} = a+b+ci is queued at issue time and
// popped by per-instance monitors whenever done is seen.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(3)) bus3 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks = 0;
  int errors = 0;
  int dones8 = 0;
  int dones3 = 0;
  logic [8:0] q8[$];
  logic [3:0] q3[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    return 9'(a) + 9'(b) + 9'(ci);
  endfunction

  function automatic logic [3:0] ref3(input logic [2:0] a, input logic [2:0] b, input logic ci);
    return 4'(a) + 4'(b) + 4'(ci);
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && bus8.done) begin
      dones8++;
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        check("result8", {bus8.co, bus8.sum}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && bus3.done) begin
      dones3++;
      if (q3.size() == 0) check("unexpected_done3", 1, 0);
      else begin
        e = q3.pop_front();
        check("result3", {bus3.co, bus3.sum}, e);
      end
    end
  end

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.done && n < 40);
    check("done8_seen", bus8.done, 1);
  endtask

  task automatic wait_done3(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus3.done && n < 20);
    check("done3_seen", bus3.done, 1);
  endtask

  // Single start pulse; measures busy length and done latency from the accepting edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int n, nbusy;
    bit seen;
    n = 0; nbusy = 0; seen = 0;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.ci = ci; bus8.start = 1'b1;
    q8.push_back(ref8(a, b, ci));
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
      if (bus8.busy) nbusy++;
      seen = bus8.done;
    end
    check("done8_seen", 64'(seen), 1);
    check("done8_latency", 64'(n), 9);
    check("busy8_cycles", 64'(nbusy), 8);
    @(negedge clk);
    check("done8_one_cycle", bus8.done, 0);
  endtask

  initial begin
    int n, n1, n2, d0;
    logic [6:0] v;
    rst_n = 1'b0;
    bus8.start = 0; bus8.a = '0; bus8.b = '0; bus8.ci = 0;
    bus3.start = 0; bus3.a = '0; bus3.b = '0; bus3.ci = 0;
    #12;
    check("reset_busy8", bus8.busy, 0);
    check("reset_done8", bus8.done, 0);
    check("reset_sum8", bus8.sum, 0);
    check("reset_co8", bus8.co, 0);
    check("reset_busy3", bus3.busy, 0);
    #10 rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);

    // Start while busy must be ignored.
    d0 = dones8;
    @(negedge clk);
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.ci = 0; bus8.start = 1'b1;
    q8.push_back(ref8(8'h10, 8'h20, 1'b0));
    @(negedge clk); bus8.start = 1'b0;
    @(negedge clk);
    @(negedge clk); bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    wait_done8(n);
    check("ignored_start_latency", 64'(n), 5);
    repeat (15) @(negedge clk);
    check("ignored_start_single_done", 64'(dones8 - d0), 1);

    // Asynchronous reset mid-run, off the clock edge.
    op8(8'hC3, 8'h5A, 1'b1);
    @(negedge clk);
    bus8.a = 8'h11; bus8.b = 8'h22; bus8.ci = 0; bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus8.busy, 0);
    check("async_rst_done", bus8.done, 0);
    check("async_rst_sum", bus8.sum, 0);
    check("async_rst_co", bus8.co, 0);
    #7 rst_n = 1'b1;
    d0 = dones8;
    repeat (15) @(negedge clk);
    check("no_done_after_reset", 64'(dones8 - d0), 0);
    op8(8'h03, 8'h04, 1'b0);

    // Start held high: back-to-back results every 9 cycles.
    @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.ci = 0; bus8.start = 1'b1;
    q8.push_back(ref8(8'h01, 8'h01, 1'b0));
    wait_done8(n1);
    bus8.a = 8'h80; bus8.b = 8'h80;
    q8.push_back(ref8(8'h80, 8'h80, 1'b0));
    wait_done8(n2);
    bus8.start = 1'b0;
    check("b2b_first_latency", 64'(n1), 9);
    check("b2b_period", 64'(n2), 9);
    @(negedge clk);
    check("b2b_returns_idle", {bus8.busy, bus8.done}, 2'b00);

    repeat (20) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Exhaustive WIDTH=3 sweep over {ci, b, a}.
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      @(negedge clk);
      bus3.a = v[2:0]; bus3.b = v[5:3]; bus3.ci = v[6]; bus3.start = 1'b1;
      q3.push_back(ref3(v[2:0], v[5:3], v[6]));
      @(negedge clk); bus3.start = 1'b0;
      wait_done3(n);
      check("done3_latency", 64'(n + 1), 4);
    end

    repeat (5) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 0);
    check("q3_drained", 64'(q3.size()), 0);
    check("dones3_total", 64'(dones3), 128);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
